// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI4 read address/data channel bundle between the arbiter (master) and the bus (slave).
interface axi_rd_arbiter_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read channel between icache and dcache, one burst in flight.
// Define AXI_RD_ARB_RR_EN for round-robin tie-breaking; otherwise the dcache wins every tie.
module axi_rd_arbiter #(
  parameter int                  ID_WIDTH   = 13,
  parameter int                  ADDR_WIDTH = 64,
  parameter int                  DATA_WIDTH = 64,
  parameter logic [ID_WIDTH-1:0] IC_ID      = 0,
  parameter logic [ID_WIDTH-1:0] DC_ID      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic [7:0]            ic_len,
  output logic                  ic_gnt,
  output logic                  ic_rvalid,
  output logic                  ic_rlast,
  input  logic                  dc_req,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [7:0]            dc_len,
  output logic                  dc_gnt,
  output logic                  dc_rvalid,
  output logic                  dc_rlast,
  output logic [DATA_WIDTH-1:0] rdata,
  axi_rd_arbiter_if.master      m_axi
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                state, state_nx;
  logic                  owner;
  logic                  pick_dc;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [ID_WIDTH-1:0]   id_q;
`ifdef AXI_RD_ARB_RR_EN
  logic last_dc;
  always_ff @(posedge clk)
    if (reset) last_dc <= 1'b0;
    else if (hs) last_dc <= owner;
  assign pick_dc = dc_req && (!ic_req || !last_dc);
`else
  // Loads must not be starved by instruction prefetch.
  assign pick_dc = dc_req;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (ic_req || dc_req)) begin
        owner  <= pick_dc;
        addr_q <= pick_dc ? dc_addr : ic_addr;
        len_q  <= pick_dc ? dc_len : ic_len;
        id_q   <= pick_dc ? DC_ID : IC_ID;
      end
    end
  always_comb begin
    state_nx        = state;
    m_axi.arvalid   = state == ADDR;
    m_axi.rready    = state == DATA;
    m_axi.arid      = id_q;
    m_axi.araddr    = addr_q;
    m_axi.arlen     = len_q;
    m_axi.arsize    = 3'b011;
    m_axi.arburst   = 2'b01;
    m_axi.arlock    = 1'b0;
    m_axi.arcache   = 4'b0000;
    m_axi.arprot    = 3'b000;
    hs              = m_axi.arvalid && m_axi.arready;
    ic_gnt          = hs && !owner;
    dc_gnt          = hs && owner;
    ic_rvalid       = m_axi.rready && !owner && m_axi.rvalid;
    dc_rvalid       = m_axi.rready && owner && m_axi.rvalid;
    ic_rlast        = ic_rvalid && m_axi.rlast;
    dc_rlast        = dc_rvalid && m_axi.rlast;
    rdata           = m_axi.rdata;
    state_nx        = state == IDLE ? ((ic_req || dc_req) ? ADDR : IDLE)
                    : state == ADDR ? (m_axi.arready ? DATA : ADDR)
                    : (state != DATA || (m_axi.rvalid && m_axi.rlast)) ? IDLE : DATA;
  end
  // Protocol violations are flagged but the beat is still delivered to the owner.
  always_ff @(posedge clk)
    if (!reset && state == DATA && m_axi.rvalid) begin
      assert (m_axi.rid == id_q) else $error("axi_rd_arbiter: rid %0h differs from arid %0h", m_axi.rid, id_q);
      assert (m_axi.rresp == 2'b00) else $error("axi_rd_arbiter: rresp %0b is not OKAY", m_axi.rresp);
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized bench with a bus slave model and a transaction-level scoreboard.
module tb_axi_rd_arbiter;
  localparam int IW = 13, AW = 64, DW = 64;
  localparam logic [IW-1:0] IC_ID = 0, DC_ID = 1;
  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } rq_t;
  typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  logic clk = 0, reset = 1;
  logic [1:0] req_v = 0;
  logic [AW-1:0] addr_v [2];
  logic [7:0] len_v [2];
  logic ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast;
  logic [DW-1:0] rdata;
  axi_rd_arbiter_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IC_ID(IC_ID), .DC_ID(DC_ID)) dut (
    .clk(clk), .reset(reset),
    .ic_req(req_v[0]), .ic_addr(addr_v[0]), .ic_len(len_v[0]), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
    .dc_req(req_v[1]), .dc_addr(addr_v[1]), .dc_len(len_v[1]), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
    .rdata(rdata), .m_axi(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] beat_data(logic [AW-1:0] a, int i);
    logic [AW-1:0] b;
    b = a + AW'(i * 8);
    return {b[31:0] ^ 32'hdeadbeef, b[63:32] ^ 32'h12345678};
  endfunction
  // Requesters: raise queued requests, hold until gnt.
  rq_t rq_ic[$], rq_dc[$];
  initial begin
    bit drop [2];
    rq_t r;
    addr_v[0] = 0; addr_v[1] = 0; len_v[0] = 0; len_v[1] = 0;
    forever begin
      @(negedge clk);
      drop[0] = req_v[0] && ic_gnt;
      drop[1] = req_v[1] && dc_gnt;
      @(posedge clk); #1;
      if (drop[0]) req_v[0] = 0;
      if (drop[1]) req_v[1] = 0;
      if (!req_v[0] && rq_ic.size() > 0) begin r = rq_ic.pop_front(); addr_v[0] = r.addr; len_v[0] = r.len; req_v[0] = 1; end
      if (!req_v[1] && rq_dc.size() > 0) begin r = rq_dc.pop_front(); addr_v[1] = r.addr; len_v[1] = r.len; req_v[1] = 1; end
    end
  end
  // AXI slave: accepts AR, returns len+1 beats with optional gaps.
  ar_t sq[$];
  int sbeat = 0, ar_block = 0;
  bit ar_rnd = 0, r_rnd = 0;
  bit rpat[$];
  initial begin
    ar_t a;
    bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sq.delete(); sbeat = 0;
      end else begin
        if (bus.arvalid && bus.arready) begin a.id = bus.arid; a.addr = bus.araddr; a.len = bus.arlen; sq.push_back(a); end
        if (bus.rvalid && bus.rready && sq.size() > 0) begin
          if (sbeat == int'(sq[0].len)) begin void'(sq.pop_front()); sbeat = 0; end
          else sbeat++;
        end
      end
      @(posedge clk); #1;
      if (bus.arvalid && ar_block > 0) begin bus.arready = 0; ar_block--; end
      else bus.arready = ar_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (sq.size() > 0) begin
        bus.rvalid = rpat.size() > 0 ? rpat.pop_front() : r_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.rid = sq[0].id;
        bus.rdata = beat_data(sq[0].addr, sbeat);
        bus.rlast = sbeat == int'(sq[0].len);
      end else begin
        bus.rvalid = 0; bus.rlast = $urandom_range(0, 1) != 0; bus.rdata = {$urandom, $urandom};
      end
    end
  end
  // Scoreboard: transaction-level view of who should own the channel and what they should see.
  int beat_cnt [2], gnt_cnt [2], last_cnt [2];
  int cyc = 0, t_last = 0, ar_gap = 0, ar_wait = 0, mbeat = 0;
  int gorder[$];
  bit busy = 0, ar_seen = 0, was_idle = 0, last_owner = 0, own = 0, ar_w = 0;
  rq_t cur;
  logic [AW-1:0] exp_addr;
  logic [7:0] exp_len;
  logic [1:0] p_req = 0;
  logic [AW-1:0] p_addr [2];
  logic [7:0] p_len [2];
  initial begin
    bit exp_av, idle_now, tie;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        busy = 0; ar_seen = 0; was_idle = 0; last_owner = 0; p_req = 0;
      end else begin
`ifdef AXI_RD_ARB_RR_EN
        tie = !last_owner;
`else
        tie = 1;
`endif
        exp_av = ar_seen || (!busy && was_idle && p_req != 0);
        idle_now = !busy && !exp_av;
        chk("arvalid", bus.arvalid, exp_av);
        chk("rready", bus.rready, busy);
        if (busy && bus.rvalid) begin
          chk("own_rvalid", own ? dc_rvalid : ic_rvalid, 1);
          chk("oth_rvalid", own ? ic_rvalid : dc_rvalid, 0);
          chk("oth_rlast", own ? ic_rlast : dc_rlast, 0);
          chk("rdata", rdata, beat_data(cur.addr, mbeat));
          chk("rlast", own ? dc_rlast : ic_rlast, mbeat == int'(cur.len));
          beat_cnt[own]++;
          if (mbeat == int'(cur.len)) begin busy = 0; last_cnt[own]++; t_last = cyc; end
          else mbeat++;
        end else chk("rvalid_quiet", {ic_rvalid, dc_rvalid, ic_rlast, dc_rlast}, 0);
        if (exp_av && !ar_seen) begin
          ar_w = p_req == 2'b11 ? tie : p_req[1];
          exp_addr = p_addr[ar_w]; exp_len = p_len[ar_w];
          ar_seen = 1; ar_wait = 0; ar_gap = cyc - t_last;
        end
        if (ar_seen) begin
          chk("araddr", bus.araddr, exp_addr);
          chk("arlen", bus.arlen, exp_len);
          chk("arid", bus.arid, ar_w ? DC_ID : IC_ID);
        end
        chk("ic_gnt", ic_gnt, ar_seen && bus.arready && !ar_w);
        chk("dc_gnt", dc_gnt, ar_seen && bus.arready && ar_w);
        if (ar_seen && bus.arready) begin
          busy = 1; own = ar_w; cur.addr = exp_addr; cur.len = exp_len; mbeat = 0;
          ar_seen = 0; last_owner = ar_w; gnt_cnt[ar_w]++; gorder.push_back(int'(ar_w));
        end else if (ar_seen) ar_wait++;
        was_idle = idle_now;
        p_req = req_v; p_addr = addr_v; p_len = len_v;
      end
    end
  end
  int b0 [2], g0 [2], l0 [2], iss [2];
  task automatic snap();
    b0 = beat_cnt; g0 = gnt_cnt; l0 = last_cnt; gorder.delete();
  endtask
  task automatic issue(int k, logic [AW-1:0] a, logic [7:0] l);
    rq_t r;
    r.addr = a; r.len = l;
    if (k == 0) rq_ic.push_back(r); else rq_dc.push_back(r);
  endtask
  task automatic wait_idle(int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(rq_ic.size() == 0 && rq_dc.size() == 0 && req_v == 0 && !busy && !ar_seen && sq.size() == 0) && n < budget);
    chk("idle_timeout", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_beats(int k, int target);
    int n = 0;
    while (beat_cnt[k] < target && n < 500) begin @(negedge clk); n++; end
    chk("beat_timeout", n < 500, 1);
  endtask
  task automatic quiet_outputs(string tag);
    chk({tag, "_arvalid"}, bus.arvalid, 0);
    chk({tag, "_rready"}, bus.rready, 0);
    chk({tag, "_gnt_rvalid"}, {ic_gnt, dc_gnt, ic_rvalid, dc_rvalid}, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    quiet_outputs("reset");
    chk("reset_ar", {bus.araddr, bus.arlen, bus.arid}, 0);
    chk("arsize", bus.arsize, 3'b011);
    chk("arburst", bus.arburst, 2'b01);
    chk("ar_misc", {bus.arlock, bus.arcache, bus.arprot}, 0);
    // Single icache burst.
    snap(); issue(0, 64'h1000, 7); wait_idle(200);
    chk("t1_gnt", gnt_cnt[0] - g0[0], 1);
    chk("t1_beats", beat_cnt[0] - b0[0], 8);
    chk("t1_last", last_cnt[0] - l0[0], 1);
    chk("t1_dc_beats", beat_cnt[1] - b0[1], 0);
    // Tie after an icache grant: dcache first in both policies.
    snap(); issue(0, 64'h2000, 3); issue(1, 64'h3000, 1); wait_idle(200);
    chk("t2a_n", gorder.size(), 2);
    chk("t2a_first", gorder[0], 1);
    chk("t2a_second", gorder[1], 0);
    // Tie after a dcache grant: policy decides.
    issue(1, 64'h4000, 2); wait_idle(200);
    snap(); issue(0, 64'h2100, 1); issue(1, 64'h3100, 2); wait_idle(200);
    chk("t2b_n", gorder.size(), 2);
`ifdef AXI_RD_ARB_RR_EN
    chk("t2b_first", gorder[0], 0);
`else
    chk("t2b_first", gorder[0], 1);
`endif
    // AR stalled for five cycles.
    snap(); ar_block = 5; issue(1, 64'h5000, 2); wait_idle(200);
    chk("t3_wait", ar_wait, 5);
    chk("t3_gnt", gnt_cnt[1] - g0[1], 1);
    // Gapped R beats.
    snap(); rpat = '{1, 0, 0, 1, 1, 0, 1}; issue(0, 64'h6000, 3); wait_idle(200);
    chk("t4_beats", beat_cnt[0] - b0[0], 4);
    chk("t4_pat_used", rpat.size(), 0);
    chk("t4_last", last_cnt[0] - l0[0], 1);
    // dcache request arriving mid icache burst.
    snap(); issue(0, 64'h7000, 5); wait_beats(0, b0[0] + 2); issue(1, 64'h8000, 4); wait_idle(200);
    chk("t5_order", {gorder.size(), gorder[0], gorder[1]}, {32'd2, 32'd0, 32'd1});
    chk("t5_gap", ar_gap, 2);
    // Reset mid-burst, then a fresh request.
    snap(); issue(0, 64'h9000, 7); wait_beats(0, b0[0] + 2);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    quiet_outputs("t6");
    snap(); issue(0, 64'hA000, 1); wait_idle(200);
    chk("t6_beats", beat_cnt[0] - b0[0], 2);
    chk("t6_gnt", gnt_cnt[0] - g0[0], 1);
    // Randomized traffic.
    snap(); ar_rnd = 1; r_rnd = 1; iss[0] = 0; iss[1] = 0;
    repeat (1500) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 7) == 0 && (k == 0 ? rq_ic.size() : rq_dc.size()) < 2) begin
          issue(k, {$urandom, $urandom} & ~64'h7, 8'($urandom_range(0, 7)));
          iss[k]++;
        end
    end
    wait_idle(3000);
    chk("rnd_ic_gnt", gnt_cnt[0] - g0[0], iss[0]);
    chk("rnd_dc_gnt", gnt_cnt[1] - g0[1], iss[1]);
    chk("rnd_lasts", (last_cnt[0] - l0[0]) + (last_cnt[1] - l0[1]), iss[0] + iss[1]);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
